// File: rtl/mem_access_pkg.sv
// Shared widths, memory op codes, FSM state encoding and op classification helpers
// for the MEM-stage bus master.
package mem_access_pkg;

  localparam int DATA_WIDTH  = 32;
  localparam int ADDR_WIDTH  = 32;
  localparam int RDATA_WIDTH = 32;
  localparam int RADDR_WIDTH = 5;

  localparam logic [DATA_WIDTH-1:0] ZERO          = 32'h0000_0000;
  localparam logic                  WRITE_DISABLE = 1'b0;

  typedef enum logic [3:0] {
    MEM_NOP = 4'd0,
    MEM_LB  = 4'd1,
    MEM_LBU = 4'd2,
    MEM_LH  = 4'd3,
    MEM_LHU = 4'd4,
    MEM_LW  = 4'd5,
    MEM_SB  = 4'd6,
    MEM_SH  = 4'd7,
    MEM_SW  = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic op_is_load(input mem_op_e op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

  function automatic logic op_is_store(input mem_op_e op);
    return op inside {MEM_SB, MEM_SH, MEM_SW};
  endfunction

  function automatic logic op_aligned(input mem_op_e op, input logic [1:0] addr_lo);
    logic ok;
    case (op)
      MEM_LH, MEM_LHU, MEM_SH: ok = (addr_lo[0] == 1'b0);
      MEM_LW, MEM_SW:          ok = (addr_lo == 2'b00);
      default:                 ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-bus req/ack interface between the MEM stage (master) and memory (slave).
interface mem_access_if;
  import mem_access_pkg::*;

  logic                  bus_req_out;
  logic [ADDR_WIDTH-1:0] bus_addr_out;
  logic                  bus_we_out;
  logic [3:0]            bus_sel_out;
  logic [DATA_WIDTH-1:0] bus_wdata_out;
  logic [DATA_WIDTH-1:0] bus_rdata_in;
  logic                  bus_ack_in;

  modport master (
    output bus_req_out, bus_addr_out, bus_we_out, bus_sel_out, bus_wdata_out,
    input  bus_rdata_in, bus_ack_in
  );

  modport slave (
    input  bus_req_out, bus_addr_out, bus_we_out, bus_sel_out, bus_wdata_out,
    output bus_rdata_in, bus_ack_in
  );

endinterface

// File: rtl/mem_access_lane_fmt.sv
// mem_lane_fmt: byte-lane select, store-data replication and load extract/extend
// from op and the low address bits. Purely combinational.
module mem_lane_fmt
  import mem_access_pkg::*;
(
  input  mem_op_e               i_op,
  input  logic [1:0]            i_addr_lo,
  input  logic [DATA_WIDTH-1:0] i_st_data,
  input  logic [DATA_WIDTH-1:0] i_ld_data,
  output logic [3:0]            o_sel,
  output logic [DATA_WIDTH-1:0] o_wdata,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_byte_sel;
  logic [3:0]  w_half_sel;

  // Lane picking and formatting for every op class.
  always_comb begin
    w_byte     = i_ld_data[{i_addr_lo, 3'b000} +: 8];
    w_half     = i_addr_lo[1] ? i_ld_data[31:16] : i_ld_data[15:0];
    w_byte_sel = 4'b0001 << i_addr_lo;
    w_half_sel = i_addr_lo[1] ? 4'b1100 : 4'b0011;
    o_sel      = 4'b0000;
    o_wdata    = ZERO;
    o_rdata    = ZERO;
    case (i_op)
      MEM_LB:  begin o_sel = w_byte_sel; o_rdata = {{24{w_byte[7]}}, w_byte}; end
      MEM_LBU: begin o_sel = w_byte_sel; o_rdata = {24'h000000, w_byte}; end
      MEM_LH:  begin o_sel = w_half_sel; o_rdata = {{16{w_half[15]}}, w_half}; end
      MEM_LHU: begin o_sel = w_half_sel; o_rdata = {16'h0000, w_half}; end
      MEM_LW:  begin o_sel = 4'b1111;    o_rdata = i_ld_data; end
      MEM_SB:  begin o_sel = w_byte_sel; o_wdata = {4{i_st_data[7:0]}}; end
      MEM_SH:  begin o_sel = w_half_sel; o_wdata = {2{i_st_data[15:0]}}; end
      MEM_SW:  begin o_sel = 4'b1111;    o_wdata = i_st_data; end
      default: begin o_sel = 4'b0000;    o_wdata = ZERO; end
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// mem_access: MEM-stage bus master turning loads/stores into single req/ack transactions.
// Optional macro MEM_BUS_TIMEOUT_EN aborts a transaction after TIMEOUT_CYCLES without ack.
module mem_access
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk_in,
  input  logic                   reset_in,
  input  logic [RDATA_WIDTH-1:0] reg_wdata_in,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_in,
  input  logic                   reg_we_in,
  input  logic [DATA_WIDTH-1:0]  mem_data_in,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_in,
  input  logic                   mem_we_in,
  input  logic [3:0]             mem_op_in,
  mem_access_if.master           bus,
  output logic [RDATA_WIDTH-1:0] reg_wdata_out,
  output logic [RADDR_WIDTH-1:0] reg_waddr_out,
  output logic                   reg_we_out,
  output logic                   stall_req_out,
  output logic                   misalign_out
);

  state_e                 r_state;
  state_e                 w_state_nxt;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [DATA_WIDTH-1:0]  r_data;
  logic [DATA_WIDTH-1:0]  r_rdata;
  mem_op_e                r_op;
  logic [RADDR_WIDTH-1:0] r_waddr;
  logic                   r_we;
  logic                   r_err;

  mem_op_e                w_op;
  logic                   w_is_mem;
  logic                   w_aligned;
  logic                   w_issue;
  logic                   w_tmo_hit;
  logic [3:0]             w_sel;
  logic [DATA_WIDTH-1:0]  w_fmt_wdata;
  logic [DATA_WIDTH-1:0]  w_fmt_rdata;
  logic                   w_unused_mem_we;

  // Op decode trusts mem_op_in; mem_we_in only duplicates it.
  assign w_unused_mem_we = mem_we_in;
  assign w_op            = mem_op_e'(mem_op_in);
  assign w_is_mem        = op_is_load(w_op) | op_is_store(w_op);
  assign w_aligned       = op_aligned(w_op, mem_addr_in[1:0]);
  assign w_issue         = (r_state == ST_IDLE) & w_is_mem & w_aligned;

  mem_lane_fmt u_fmt (
    .i_op      (r_op),
    .i_addr_lo (r_addr[1:0]),
    .i_st_data (r_data),
    .i_ld_data (r_rdata),
    .o_sel     (w_sel),
    .o_wdata   (w_fmt_wdata),
    .o_rdata   (w_fmt_rdata)
  );

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [TMO_W-1:0] r_tmo_cnt;

  // Counts BUSY cycles since the transaction was issued.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_tmo_cnt <= {TMO_W{1'b0}};
    end else if (w_issue) begin
      r_tmo_cnt <= {TMO_W{1'b0}};
    end else if (r_state == ST_BUSY) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end else begin
      r_tmo_cnt <= r_tmo_cnt;
    end
  end

  assign w_tmo_hit = (r_state == ST_BUSY) & (r_tmo_cnt == TMO_LAST);
`else
  // Never fires; the parameter stays referenced so both builds share one interface.
  assign w_tmo_hit = (TIMEOUT_CYCLES < 32'sd0);
`endif

  // State register and transaction capture.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state <= ST_IDLE;
      r_addr  <= {ADDR_WIDTH{1'b0}};
      r_data  <= ZERO;
      r_rdata <= ZERO;
      r_op    <= MEM_NOP;
      r_waddr <= {RADDR_WIDTH{1'b0}};
      r_we    <= WRITE_DISABLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_addr  <= mem_addr_in;
        r_data  <= mem_data_in;
        r_op    <= w_op;
        r_waddr <= reg_waddr_in;
        r_we    <= reg_we_in;
        r_err   <= 1'b0;
      end
      if ((r_state == ST_BUSY) && bus.bus_ack_in) begin
        r_rdata <= bus.bus_rdata_in;
      end else if (w_tmo_hit) begin
        r_err <= 1'b1;
      end
    end
  end

  // Next state and all outputs; reset low forces every output to zero at once.
  always_comb begin
    w_state_nxt       = r_state;
    bus.bus_req_out   = 1'b0;
    bus.bus_addr_out  = {ADDR_WIDTH{1'b0}};
    bus.bus_we_out    = 1'b0;
    bus.bus_sel_out   = 4'b0000;
    bus.bus_wdata_out = ZERO;
    reg_wdata_out     = ZERO;
    reg_waddr_out     = {RADDR_WIDTH{1'b0}};
    reg_we_out        = WRITE_DISABLE;
    stall_req_out     = 1'b0;
    misalign_out      = 1'b0;
    if (reset_in) begin
      case (r_state)
        ST_IDLE: begin
          if (!w_is_mem) begin
            reg_wdata_out = reg_wdata_in;
            reg_waddr_out = reg_waddr_in;
            reg_we_out    = reg_we_in;
          end else if (!w_aligned) begin
            misalign_out  = 1'b1;
          end else begin
            stall_req_out = 1'b1;
            w_state_nxt   = ST_BUSY;
          end
        end
        ST_BUSY: begin
          bus.bus_req_out   = 1'b1;
          bus.bus_addr_out  = {r_addr[ADDR_WIDTH-1:2], 2'b00};
          bus.bus_we_out    = op_is_store(r_op);
          bus.bus_sel_out   = w_sel;
          bus.bus_wdata_out = w_fmt_wdata;
          stall_req_out     = 1'b1;
          if (bus.bus_ack_in || w_tmo_hit) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_BUSY;
          end
        end
        ST_DONE: begin
          reg_waddr_out = r_waddr;
          w_state_nxt   = ST_IDLE;
          if (r_err) begin
            misalign_out  = 1'b1;
          end else if (op_is_load(r_op)) begin
            reg_we_out    = 1'b1;
            reg_wdata_out = w_fmt_rdata;
          end else begin
            reg_we_out    = r_we;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
        end
      endcase
    end else begin
      w_state_nxt   = ST_IDLE;
      stall_req_out = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, hand-written corner
// sequences and randomized transactions checked against an arithmetic reference model.
module tb_mem_access;
  import mem_access_pkg::*;

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int TMO = 8;
`else
  localparam int TMO = 256;
`endif

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic [31:0] reg_wdata_in;
  logic [4:0]  reg_waddr_in;
  logic        reg_we_in;
  logic [31:0] mem_data_in;
  logic [31:0] mem_addr_in;
  logic        mem_we_in;
  logic [3:0]  mem_op_in;
  logic [31:0] reg_wdata_out;
  logic [4:0]  reg_waddr_out;
  logic        reg_we_out;
  logic        stall_req_out;
  logic        misalign_out;

  mem_access_if bus ();

  mem_access #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .reg_wdata_in  (reg_wdata_in),
    .reg_waddr_in  (reg_waddr_in),
    .reg_we_in     (reg_we_in),
    .mem_data_in   (mem_data_in),
    .mem_addr_in   (mem_addr_in),
    .mem_we_in     (mem_we_in),
    .mem_op_in     (mem_op_in),
    .bus           (bus),
    .reg_wdata_out (reg_wdata_out),
    .reg_waddr_out (reg_waddr_out),
    .reg_we_out    (reg_we_out),
    .stall_req_out (stall_req_out),
    .misalign_out  (misalign_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string       nm;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] rdata;
    int          dly;
    logic        rwe;
    logic [3:0]  sel;
    logic [31:0] bwd;
    logic [31:0] rwd;
    logic        e_rwe;
    logic        mis;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    mem_op_in = MEM_NOP; mem_addr_in = 32'h0; mem_data_in = 32'h0; mem_we_in = 1'b0;
    reg_we_in = 1'b0; reg_waddr_in = 5'd0; reg_wdata_in = 32'h0;
    bus.bus_ack_in = 1'b0; bus.bus_rdata_in = 32'h0;
  endtask

  function automatic logic is_ld(input logic [3:0] op);
    return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
  endfunction

  // Reference: lane math from access size and byte offset.
  function automatic void model(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] data,
                                input logic [31:0] rdata, output logic [3:0] sel,
                                output logic [31:0] bwd, output logic [31:0] rwd, output logic mis);
    int size; int ofs; longint v; longint m;
    size = (op == MEM_LB || op == MEM_LBU || op == MEM_SB) ? 1 :
           (op == MEM_LH || op == MEM_LHU || op == MEM_SH) ? 2 : 4;
    ofs  = int'(addr % 4);
    mis  = (addr % size) != 0;
    sel  = 4'(((1 << size) - 1) << ofs);
    m    = (longint'(1) << (8 * size)) - 1;
    bwd  = 32'h0;
    rwd  = 32'h0;
    if (op == MEM_SB) bwd = data[7:0] * 32'h0101_0101;
    if (op == MEM_SH) bwd = data[15:0] * 32'h0001_0001;
    if (op == MEM_SW) bwd = data;
    v = (longint'(rdata) >> (8 * ofs)) & m;
    if ((op == MEM_LB || op == MEM_LH) && v >= (m + 1) / 2) v = v - (m + 1);
    if (is_ld(op)) rwd = 32'(v);
  endfunction

  task automatic run_txn(input string nm, input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input logic [31:0] rdata, input int dly,
                         input logic rwe, input logic [4:0] waddr, input logic [3:0] e_sel,
                         input logic [31:0] e_bwd, input logic [31:0] e_rwd,
                         input logic e_rwe, input logic e_mis);
    logic ld; logic st; int req_cnt; int stall_cnt;
    ld = is_ld(op);
    st = op inside {MEM_SB, MEM_SH, MEM_SW};
    @(posedge clk_in); #1;
    mem_op_in = op; mem_addr_in = addr; mem_data_in = data; mem_we_in = st;
    reg_we_in = rwe; reg_waddr_in = waddr; reg_wdata_in = $urandom;
    @(negedge clk_in);
    if (e_mis) begin
      chk({nm, " misalign"}, 32'(misalign_out), 32'd1);
      chk({nm, " mis_stall"}, 32'(stall_req_out), 32'd0);
      chk({nm, " mis_reg_we"}, 32'(reg_we_out), 32'd0);
      chk({nm, " mis_req"}, 32'(bus.bus_req_out), 32'd0);
      @(posedge clk_in); #1; drive_idle();
      @(negedge clk_in);
      chk({nm, " mis_no_txn"}, 32'(bus.bus_req_out), 32'd0);
      chk({nm, " mis_one_cycle"}, 32'(misalign_out), 32'd0);
    end else begin
      chk({nm, " issue_stall"}, 32'(stall_req_out), 32'd1);
      chk({nm, " issue_reg_we"}, 32'(reg_we_out), 32'd0);
      stall_cnt = stall_req_out ? 1 : 0;
      req_cnt   = 0;
      for (int k = 1; k <= dly; k++) begin
        @(posedge clk_in); #1;
        bus.bus_ack_in   = (k == dly);
        bus.bus_rdata_in = (k == dly) ? rdata : $urandom;
        @(negedge clk_in);
        if (bus.bus_req_out) req_cnt++;
        if (stall_req_out) stall_cnt++;
        if (k == dly) begin
          chk({nm, " bus_addr"}, bus.bus_addr_out, {addr[31:2], 2'b00});
          chk({nm, " bus_sel"}, 32'(bus.bus_sel_out), 32'(e_sel));
          chk({nm, " bus_we"}, 32'(bus.bus_we_out), 32'(st));
          chk({nm, " bus_wdata"}, bus.bus_wdata_out, e_bwd);
        end
      end
      chk({nm, " req_cycles"}, 32'(req_cnt), 32'(dly));
      chk({nm, " stall_cycles"}, 32'(stall_cnt), 32'(dly + 1));
      @(posedge clk_in); #1;
      bus.bus_ack_in = 1'b0; bus.bus_rdata_in = $urandom;
      @(negedge clk_in);
      chk({nm, " done_stall"}, 32'(stall_req_out), 32'd0);
      chk({nm, " done_req"}, 32'(bus.bus_req_out), 32'd0);
      chk({nm, " done_reg_we"}, 32'(reg_we_out), 32'(e_rwe));
      chk({nm, " done_waddr"}, 32'(reg_waddr_out), 32'(waddr));
      if (ld) chk({nm, " done_wdata"}, reg_wdata_out, e_rwd);
      @(posedge clk_in); #1; drive_idle();
      @(negedge clk_in);
      chk({nm, " back_idle"}, 32'(bus.bus_req_out | stall_req_out), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [3:0] r_op; logic [31:0] r_addr; logic [31:0] r_data; logic [31:0] r_rd;
    logic [3:0] e_sel; logic [31:0] e_bwd; logic [31:0] e_rwd; logic e_mis; logic r_rwe;
    int cnt;

    tbl[0]  = '{"lw_ack3",  MEM_LW,  32'h100, 32'h0,        32'h12345678, 3, 1'b0, 4'hF, 32'h0,        32'h12345678, 1'b1, 1'b0};
    tbl[1]  = '{"lb_103",   MEM_LB,  32'h103, 32'h0,        32'h80FFFFFF, 1, 1'b1, 4'h8, 32'h0,        32'hFFFFFF80, 1'b1, 1'b0};
    tbl[2]  = '{"lbu_103",  MEM_LBU, 32'h103, 32'h0,        32'h80FFFFFF, 2, 1'b1, 4'h8, 32'h0,        32'h00000080, 1'b1, 1'b0};
    tbl[3]  = '{"sh_202",   MEM_SH,  32'h202, 32'hAAAABEEF, 32'h0,        2, 1'b0, 4'hC, 32'hBEEFBEEF, 32'h0,        1'b0, 1'b0};
    tbl[4]  = '{"lw_mis",   MEM_LW,  32'h101, 32'h0,        32'h0,        1, 1'b1, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1};
    tbl[5]  = '{"lh_102",   MEM_LH,  32'h102, 32'h0,        32'h80017FFF, 1, 1'b1, 4'hC, 32'h0,        32'hFFFF8001, 1'b1, 1'b0};
    tbl[6]  = '{"lhu_100",  MEM_LHU, 32'h100, 32'h0,        32'h1234ABCD, 4, 1'b1, 4'h3, 32'h0,        32'h0000ABCD, 1'b1, 1'b0};
    tbl[7]  = '{"sb_301",   MEM_SB,  32'h301, 32'h000000A5, 32'h0,        1, 1'b0, 4'h2, 32'hA5A5A5A5, 32'h0,        1'b0, 1'b0};
    tbl[8]  = '{"sw_we",    MEM_SW,  32'h400, 32'hDEADBEEF, 32'h0,        2, 1'b1, 4'hF, 32'hDEADBEEF, 32'h0,        1'b1, 1'b0};
    tbl[9]  = '{"sh_mis",   MEM_SH,  32'h203, 32'h1234,     32'h0,        1, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1};
    tbl[10] = '{"lb_001",   MEM_LB,  32'h001, 32'h0,        32'h00007F00, 1, 1'b1, 4'h2, 32'h0,        32'h0000007F, 1'b1, 1'b0};

    // Reset with a load presented on the inputs: everything must stay quiet.
    drive_idle();
    reset_in = 1'b0;
    mem_op_in = MEM_LW; mem_addr_in = 32'h100; reg_we_in = 1'b1; reg_wdata_in = 32'h77;
    #3;
    chk("rst_stall", 32'(stall_req_out), 32'd0);
    chk("rst_req", 32'(bus.bus_req_out), 32'd0);
    chk("rst_reg_we", 32'(reg_we_out), 32'd0);
    chk("rst_reg_wdata", reg_wdata_out, 32'h0);
    chk("rst_misalign", 32'(misalign_out), 32'd0);
    chk("rst_bus_addr_sel", bus.bus_addr_out | 32'(bus.bus_sel_out), 32'h0);
    repeat (2) @(posedge clk_in);
    #1; drive_idle(); reset_in = 1'b1;

    // Non-memory pass-through in the same cycle.
    @(posedge clk_in); #1;
    reg_wdata_in = 32'h55; reg_waddr_in = 5'd7; reg_we_in = 1'b1; mem_op_in = MEM_NOP;
    #1;
    chk("pass_wdata", reg_wdata_out, 32'h55);
    chk("pass_waddr", 32'(reg_waddr_out), 32'd7);
    chk("pass_we", 32'(reg_we_out), 32'd1);
    chk("pass_no_stall", 32'(stall_req_out | bus.bus_req_out), 32'd0);

    // Stray ack while idle is ignored.
    @(posedge clk_in); #1; drive_idle(); bus.bus_ack_in = 1'b1;
    @(posedge clk_in); #1; bus.bus_ack_in = 1'b0;
    @(negedge clk_in);
    chk("idle_ack_ignored", 32'(bus.bus_req_out | stall_req_out | reg_we_out), 32'd0);

    for (int i = 0; i < 11; i++) begin
      run_txn(tbl[i].nm, tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].rdata, tbl[i].dly,
              tbl[i].rwe, 5'(i + 1), tbl[i].sel, tbl[i].bwd, tbl[i].rwd, tbl[i].e_rwe, tbl[i].mis);
    end

    // Reset mid-BUSY aborts immediately.
    @(posedge clk_in); #1;
    mem_op_in = MEM_LW; mem_addr_in = 32'h100; reg_we_in = 1'b1; reg_waddr_in = 5'd4;
    @(posedge clk_in); #1;
    @(negedge clk_in);
    chk("midrst_busy_req", 32'(bus.bus_req_out), 32'd1);
    #1; reset_in = 1'b0; #1;
    chk("midrst_req", 32'(bus.bus_req_out), 32'd0);
    chk("midrst_stall", 32'(stall_req_out), 32'd0);
    @(posedge clk_in); #1; drive_idle(); reset_in = 1'b1;
    @(negedge clk_in);
    chk("midrst_after", 32'(bus.bus_req_out | stall_req_out), 32'd0);

`ifdef MEM_BUS_TIMEOUT_EN
    @(posedge clk_in); #1;
    mem_op_in = MEM_LW; mem_addr_in = 32'h500; reg_we_in = 1'b1; reg_waddr_in = 5'd9;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_in); #1;
      @(negedge clk_in);
      if (!bus.bus_req_out) break;
      cnt++;
    end
    chk("tmo_busy_cycles", 32'(cnt), 32'd8);
    chk("tmo_misalign", 32'(misalign_out), 32'd1);
    chk("tmo_reg_we", 32'(reg_we_out), 32'd0);
    chk("tmo_reg_wdata", reg_wdata_out, 32'h0);
    chk("tmo_stall", 32'(stall_req_out), 32'd0);
    @(posedge clk_in); #1; drive_idle();
    @(negedge clk_in);
    chk("tmo_pulse_end", 32'(misalign_out), 32'd0);
    run_txn("ack_at_limit", MEM_LW, 32'h504, 32'h0, 32'hCAFEF00D, 8, 1'b1, 5'd10,
            4'hF, 32'h0, 32'hCAFEF00D, 1'b1, 1'b0);
`else
    @(posedge clk_in); #1;
    mem_op_in = MEM_LW; mem_addr_in = 32'h500; reg_we_in = 1'b1; reg_waddr_in = 5'd9;
    repeat (20) @(posedge clk_in);
    @(negedge clk_in);
    chk("no_tmo_still_req", 32'(bus.bus_req_out), 32'd1);
    chk("no_tmo_still_stall", 32'(stall_req_out), 32'd1);
    #1; bus.bus_ack_in = 1'b1; bus.bus_rdata_in = 32'h0BADF00D;
    @(posedge clk_in); #1; bus.bus_ack_in = 1'b0;
    @(negedge clk_in);
    chk("no_tmo_done_we", 32'(reg_we_out), 32'd1);
    chk("no_tmo_done_data", reg_wdata_out, 32'h0BADF00D);
    @(posedge clk_in); #1; drive_idle();
`endif

    for (int i = 0; i < 40; i++) begin
      r_op   = 4'($urandom_range(1, 8));
      r_addr = $urandom;
      r_data = $urandom;
      r_rd   = $urandom;
      r_rwe  = 1'($urandom_range(0, 1));
      model(r_op, r_addr, r_data, r_rd, e_sel, e_bwd, e_rwd, e_mis);
      run_txn($sformatf("rnd%0d", i), r_op, r_addr, r_data, r_rd, int'($urandom_range(1, 4)),
              r_rwe, 5'($urandom), e_sel, e_bwd, e_rwd, is_ld(r_op) ? 1'b1 : r_rwe, e_mis);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
